// File: rtl/mmu_ctx_sequencer.sv
// mmu_ctx_sequencer: shadow page-table context burst engine and live-map write arbiter.
// Optional MMU_CTX_IRQ_EN adds irq/irq_ack completion interrupt.
module mmu_ctx_sequencer #(
  parameter int NCTX = 4,
  parameter int ENTRY_W = 3,
  parameter int NPAGES = 8,
  localparam int CW = $clog2(NCTX)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_wr,
  input  logic [2:0]         cpu_adr,
  input  logic [ENTRY_W-1:0] cpu_data,
  input  logic               map_unlock,
  input  logic               shd_wr,
  input  logic [CW-1:0]      shd_ctx,
  input  logic [2:0]         shd_adr,
  input  logic [ENTRY_W-1:0] shd_data,
  input  logic               ctx_go,
  input  logic [CW-1:0]      ctx_sel,
  output logic               mm_we,
  output logic [2:0]         mm_adr,
  output logic [ENTRY_W-1:0] mm_data,
  output logic               busy,
  output logic               done,
  output logic               cpu_wait,
  output logic               go_ovr
`ifdef MMU_CTX_IRQ_EN
  ,
  input  logic               irq_ack,
  output logic               irq
`endif
);
  typedef enum logic [1:0] {IDLE, DEFER, LOAD, FIN} state_t;
  state_t state, state_nx;
  logic [2:0] idx;
  logic [CW-1:0] ctx;
  logic pend, iss, ovr, last, take, direct, flush;
  logic [2:0] pend_adr, iss_adr;
  logic [ENTRY_W-1:0] pend_data, iss_data;
  logic [ENTRY_W-1:0] shadow [NCTX][NPAGES];
  // DEFER gives a same-edge CPU write the port before the burst starts
  always_comb begin
    state_nx = state == IDLE  ? (ctx_go ? (cpu_wr ? DEFER : LOAD) : IDLE) :
               state == DEFER ? LOAD :
               state == LOAD  ? (last ? FIN : LOAD) : IDLE;
    last   = state == LOAD && idx == 3'(NPAGES - 1);
    take   = cpu_wr && !pend && (state == DEFER || state == LOAD);
    direct = cpu_wr && map_unlock && (state == IDLE || (state == FIN && !pend));
    flush  = last && map_unlock && (pend || cpu_wr);
  end
  assign busy     = state == LOAD;
  assign done     = state == FIN;
  assign cpu_wait = pend;
  assign go_ovr   = ovr;
  assign mm_we    = busy | iss;
  assign mm_adr   = busy ? idx : iss_adr;
  assign mm_data  = busy ? shadow[ctx][idx] : iss_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      ctx       <= '0;
      pend      <= 1'b0;
      pend_adr  <= '0;
      pend_data <= '0;
      iss       <= 1'b0;
      iss_adr   <= '0;
      iss_data  <= '0;
      ovr       <= 1'b0;
      for (int c = 0; c < NCTX; c++)
        for (int p = 0; p < NPAGES; p++)
          shadow[c][p] <= ENTRY_W'(p != 0);
    end else begin
      state <= state_nx;
      idx   <= busy ? idx + 3'd1 : 3'd0;
      if (state == IDLE && ctx_go) ctx <= ctx_sel;
      pend <= state == FIN ? 1'b0 : pend | take;
      if (take) begin
        pend_adr  <= cpu_adr;
        pend_data <= cpu_data;
      end
      iss <= direct | flush;
      if (direct | flush) begin
        iss_adr  <= flush && pend ? pend_adr : cpu_adr;
        iss_data <= flush && pend ? pend_data : cpu_data;
      end
      if (ctx_go && state != IDLE) ovr <= 1'b1;
      if (shd_wr) shadow[shd_ctx][shd_adr] <= shd_data;
    end
`ifdef MMU_CTX_IRQ_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq <= 1'b0;
    else irq <= state_nx == FIN || (irq && !irq_ack);
`endif
endmodule

// File: tb/tb_mmu_ctx_sequencer.sv
// tb_mmu_ctx_sequencer: directed literal checks plus randomized run against a behavioural model.
module tb_mmu_ctx_sequencer;
  logic clk = 0, reset = 0;
  logic cpu_wr = 0, map_unlock = 1, shd_wr = 0, ctx_go = 0;
  logic [2:0] cpu_adr = 0, cpu_data = 0, shd_adr = 0, shd_data = 0;
  logic [1:0] shd_ctx = 0, ctx_sel = 0;
  logic mm_we, busy, done, cpu_wait, go_ovr;
  logic [2:0] mm_adr, mm_data;
`ifdef MMU_CTX_IRQ_EN
  logic irq, irq_ack = 0;
`endif
  int n_chk = 0, n_fail = 0;

  mmu_ctx_sequencer dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr), .cpu_data(cpu_data),
    .map_unlock(map_unlock), .shd_wr(shd_wr), .shd_ctx(shd_ctx), .shd_adr(shd_adr),
    .shd_data(shd_data), .ctx_go(ctx_go), .ctx_sel(ctx_sel), .mm_we(mm_we), .mm_adr(mm_adr),
    .mm_data(mm_data), .busy(busy), .done(done), .cpu_wait(cpu_wait), .go_ovr(go_ovr)
`ifdef MMU_CTX_IRQ_EN
    , .irq_ack(irq_ack), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: pos -1 idle, -2 burst deferred behind a CPU write, 0..7 entry on the port, 8 finishing
  int pos, mctx;
  bit mpend, was_pend, miss, movr;
  bit [2:0] mp_adr, mp_data, mi_adr, mi_data;
  bit [2:0] msh [4][8];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos = -1; mctx = 0; mpend = 0; miss = 0; mi_adr = 0; mi_data = 0; movr = 0;
      for (int c = 0; c < 4; c++)
        for (int p = 0; p < 8; p++) msh[c][p] = (p == 0) ? 3'd0 : 3'd1;
    end else begin
      was_pend = mpend;
      miss = 0;
      if (ctx_go && pos != -1) movr = 1;
      if (cpu_wr && !mpend && (pos == -2 || (pos >= 0 && pos <= 7))) begin
        mpend = 1; mp_adr = cpu_adr; mp_data = cpu_data;
      end
      if (pos == -1) begin
        if (cpu_wr && map_unlock) begin miss = 1; mi_adr = cpu_adr; mi_data = cpu_data; end
        if (ctx_go) begin mctx = int'(ctx_sel); pos = cpu_wr ? -2 : 0; end
      end else if (pos == -2) pos = 0;
      else if (pos < 7) pos++;
      else if (pos == 7) begin
        if (mpend && map_unlock) begin miss = 1; mi_adr = mp_adr; mi_data = mp_data; end
        pos = 8;
      end else begin
        if (!was_pend && cpu_wr && map_unlock) begin miss = 1; mi_adr = cpu_adr; mi_data = cpu_data; end
        mpend = 0;
        pos = -1;
      end
      if (shd_wr) msh[shd_ctx][shd_adr] = shd_data;
    end
  end

  bit e_burst;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      e_burst = pos >= 0 && pos <= 7;
      chk("mm_we", mm_we, e_burst || miss);
      if (e_burst) begin
        chk("mm_adr burst", mm_adr, pos);
        chk("mm_data burst", mm_data, msh[mctx][pos[2:0]]);
      end else if (miss) begin
        chk("mm_adr cpu", mm_adr, mi_adr);
        chk("mm_data cpu", mm_data, mi_data);
      end
      chk("busy", busy, e_burst);
      chk("done", done, pos == 8);
      chk("cpu_wait", cpu_wait, mpend);
      chk("go_ovr", go_ovr, movr);
    end
  end

  initial begin
    repeat (3) tick;
    chk("rst mm_we", mm_we, 0); chk("rst mm_adr", mm_adr, 0); chk("rst mm_data", mm_data, 0);
    chk("rst busy", busy, 0); chk("rst done", done, 0); chk("rst cpu_wait", cpu_wait, 0);
    chk("rst go_ovr", go_ovr, 0);
    reset = 1;
    tick;
    // default context burst
    ctx_go = 1; ctx_sel = 0;
    tick; ctx_go = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick;
      chk("t1 we", mm_we, 1); chk("t1 adr", mm_adr, i); chk("t1 data", mm_data, i == 0 ? 0 : 1);
    end
    tick; chk("t1 done", done, 1); chk("t1 busy", busy, 0); chk("t1 we off", mm_we, 0);
    tick; chk("t1 done pulse", done, 0);
    // shadow write then burst of that context
    shd_wr = 1; shd_ctx = 2; shd_adr = 5; shd_data = 6;
    tick; shd_wr = 0; ctx_go = 1; ctx_sel = 2;
    tick; ctx_go = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick;
      chk("t2 data", mm_data, i == 5 ? 6 : (i == 0 ? 0 : 1));
    end
    repeat (2) tick;
    // CPU write collides with burst
    ctx_go = 1; ctx_sel = 1;
    tick; ctx_go = 0;
    tick; tick;
    cpu_wr = 1; cpu_adr = 3; cpu_data = 4;
    tick; cpu_wr = 0;
    for (int k = 4; k <= 8; k++) begin
      if (k > 4) tick;
      chk("t3 wait", cpu_wait, 1);
    end
    tick;
    chk("t3 wait fin", cpu_wait, 1); chk("t3 done", done, 1);
    chk("t3 we", mm_we, 1); chk("t3 adr", mm_adr, 3); chk("t3 data", mm_data, 4);
    tick; chk("t3 wait drop", cpu_wait, 0); chk("t3 we off", mm_we, 0);
    // locked map discards CPU writes but not bursts
    map_unlock = 0; cpu_wr = 1; cpu_adr = 2; cpu_data = 7;
    tick; cpu_wr = 0;
    tick; chk("t4 no we", mm_we, 0);
    ctx_go = 1; ctx_sel = 0;
    tick; ctx_go = 0;
    begin
      int cnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (i > 0) tick;
        if (mm_we) cnt++;
      end
      chk("t4 strobes", cnt, 8);
    end
    tick; map_unlock = 1;
    tick;
    // same-edge CPU write and ctx_go
    cpu_wr = 1; cpu_adr = 6; cpu_data = 5; ctx_go = 1; ctx_sel = 0;
    tick; cpu_wr = 0; ctx_go = 0;
    chk("t5 cpu we", mm_we, 1); chk("t5 cpu adr", mm_adr, 6); chk("t5 cpu data", mm_data, 5);
    chk("t5 not busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      tick; chk("t5 burst adr", mm_adr, i); chk("t5 busy", busy, 1);
    end
    tick; chk("t5 done", done, 1);
    tick;
    // ctx_go while busy, then reset mid-burst
    ctx_go = 1; ctx_sel = 3;
    tick; ctx_go = 0;
    tick; ctx_go = 1;
    tick; ctx_go = 0; chk("t6 ovr", go_ovr, 1); chk("t6 adr", mm_adr, 2);
    tick; #2 reset = 0; #1;
    chk("t6 rst we", mm_we, 0); chk("t6 rst busy", busy, 0); chk("t6 rst ovr", go_ovr, 0);
    tick; reset = 1;
    for (int i = 0; i < 10; i++) begin
      tick; chk("t6 no done", done, 0);
    end
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cpu_wr = $urandom_range(5) == 0; cpu_adr = 3'($urandom); cpu_data = 3'($urandom);
      map_unlock = $urandom_range(3) != 0;
      shd_wr = $urandom_range(3) == 0; shd_ctx = 2'($urandom); shd_adr = 3'($urandom);
      shd_data = 3'($urandom);
      ctx_go = $urandom_range(7) == 0; ctx_sel = 2'($urandom);
      tick;
      if ($urandom_range(400) == 0) begin
        #2 reset = 0;
        tick; reset = 1;
      end
    end
    cpu_wr = 0; shd_wr = 0; ctx_go = 0;
    repeat (12) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
